mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Multi-cycle load/store unit sitting between the execute stage and a
//   synchronous data RAM. It accepts one request at a time, formats store
//   data into byte lanes and extends load data. Faulting requests are
//   answered without touching the RAM.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; ready is high only when idle
//   L_type, S_type       load / store request
//   data_type            000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, data_in        byte address, LSB-aligned store data
//   resp_valid           one-cycle completion pulse
//   Read_data            formatted load data (0 for stores and faults)
//   misalign, illegal    fault flags, valid with resp_valid
//   ram_en/we/be/addr/wdata, ram_rdata   RAM interface
module mem_access_unit #(
  parameter int RAM_AW = 8,
  parameter int RD_LAT = 1   // 1..7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              L_type,
  input  logic              S_type,
  input  logic [2:0]        data_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  output logic              resp_valid,
  output logic [31:0]       Read_data,
  output logic              misalign,
  output logic              illegal,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  // Latched request attributes needed after accept
  logic              is_load_reg, is_load_next;
  logic [2:0]        dtype_reg, dtype_next;
  logic [1:0]        addr_lo_reg, addr_lo_next;
  logic [2:0]        cnt_reg, cnt_next;

  // Registered outputs
  logic              resp_valid_reg, resp_valid_next;
  logic [31:0]       read_data_reg, read_data_next;
  logic              misalign_reg, misalign_next;
  logic              illegal_reg, illegal_next;
  logic              ram_en_reg, ram_en_next;
  logic              ram_we_reg, ram_we_next;
  logic [3:0]        ram_be_reg, ram_be_next;
  logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
  logic [31:0]       ram_wdata_reg, ram_wdata_next;

  // Request checks on the incoming request
  logic illegal_chk, misalign_chk;
  always_comb begin
    // 011, 110, 111 are undefined; 100/101 are load-only
    illegal_chk = (L_type & S_type)
                | (data_type[1:0] == 2'b11)
                | (data_type[2] & data_type[1])
                | (data_type[2] & S_type);
    misalign_chk = ((data_type[1:0] == 2'b01) & addr[0])
                 | ((data_type[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Store lane formatting from the incoming request
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;
  always_comb begin
    case (data_type[1:0])
      2'b00: begin
        wdata_fmt = {4{data_in[7:0]}};
        be_fmt    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{data_in[15:0]}};
        be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_fmt = data_in;
        be_fmt    = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension
  logic [31:0] lane;
  logic [31:0] load_fmt;
  always_comb begin
    lane = ram_rdata >> {addr_lo_reg, 3'b000};
    case (dtype_reg)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    is_load_next    = is_load_reg;
    dtype_next      = dtype_reg;
    addr_lo_next    = addr_lo_reg;
    cnt_next        = cnt_reg;
    resp_valid_next = 1'b0;
    read_data_next  = read_data_reg;
    misalign_next   = 1'b0;
    illegal_next    = 1'b0;
    ram_en_next     = 1'b0;
    ram_we_next     = 1'b0;
    ram_be_next     = 4'b0000;
    ram_addr_next   = ram_addr_reg;
    ram_wdata_next  = ram_wdata_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid && (L_type || S_type)) begin
          is_load_next = L_type & ~S_type;
          dtype_next   = data_type;
          addr_lo_next = addr[1:0];
          if (illegal_chk || misalign_chk) begin
            // Answer straight away; the RAM is never strobed
            state_next      = RESP;
            resp_valid_next = 1'b1;
            illegal_next    = illegal_chk;
            misalign_next   = misalign_chk & ~illegal_chk;
            read_data_next  = 32'd0;
          end else begin
            state_next    = ISSUE;
            ram_en_next   = 1'b1;
            ram_addr_next = addr[RAM_AW+1:2];
            if (S_type) begin
              ram_we_next    = 1'b1;
              ram_be_next    = be_fmt;
              ram_wdata_next = wdata_fmt;
            end
          end
        end
      end
      ISSUE: begin
        if (is_load_reg) begin
          state_next = WAIT;
          cnt_next   = 3'(RD_LAT - 1);
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          read_data_next  = 32'd0;
        end
      end
      WAIT: begin
        // Counter hits zero in the cycle ram_rdata becomes valid
        if (cnt_reg == 3'd0) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          read_data_next  = load_fmt;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: state_next = IDLE;  // RESP
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      is_load_reg    <= 1'b0;
      dtype_reg      <= 3'd0;
      addr_lo_reg    <= 2'd0;
      cnt_reg        <= 3'd0;
      resp_valid_reg <= 1'b0;
      read_data_reg  <= 32'd0;
      misalign_reg   <= 1'b0;
      illegal_reg    <= 1'b0;
      ram_en_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_be_reg     <= 4'd0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      is_load_reg    <= is_load_next;
      dtype_reg      <= dtype_next;
      addr_lo_reg    <= addr_lo_next;
      cnt_reg        <= cnt_next;
      resp_valid_reg <= resp_valid_next;
      read_data_reg  <= read_data_next;
      misalign_reg   <= misalign_next;
      illegal_reg    <= illegal_next;
      ram_en_reg     <= ram_en_next;
      ram_we_reg     <= ram_we_next;
      ram_be_reg     <= ram_be_next;
      ram_addr_reg   <= ram_addr_next;
      ram_wdata_reg  <= ram_wdata_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign Read_data  = read_data_reg;
  assign misalign   = misalign_reg;
  assign illegal    = illegal_reg;
  assign ram_en     = ram_en_reg;
  assign ram_we     = ram_we_reg;
  assign ram_be     = ram_be_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = ram_wdata_reg;

  // Address bits above the RAM window are not decoded
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:RAM_AW+2];

endmodule
